// File: rtl/pipe_skid_stage.sv
// Two-entry skid stage: registered in_ready (no out_ready -> in_ready path),
// full throughput at occupancy 1, and a skid entry that absorbs one word of
// backpressure so upstream only sees in_ready drop one cycle late.
module pipe_skid_stage #(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             en,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  // Occupancy doubles as the FSM state; encoding equals the count value.
  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StTwo   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             push, pop;

  // in_ready depends only on registered state and local controls. resetn is
  // folded in so the stage refuses offers while held in reset.
  assign in_ready  = resetn & en & ~flush & (state_q != StTwo);
  assign out_valid = resetn & en & ~flush & (state_q != StEmpty);
  assign out_data  = head_q;
  assign count     = state_q;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // Next-state: flush beats enable, enable-low holds, otherwise handshake update.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = StEmpty;
      head_d  = RESET_VAL;
      skid_d  = RESET_VAL;
    end else if (en) begin
      case (state_q)
        StEmpty: begin
          if (push) begin
            head_d  = in_data;
            state_d = StOne;
          end
        end
        StOne: begin
          if (push && pop) begin
            head_d = in_data;
          end else if (push) begin
            skid_d  = in_data;
            state_d = StTwo;
          end else if (pop) begin
            state_d = StEmpty;
          end
        end
        StTwo: begin
          // push cannot occur here: in_ready is low at full occupancy.
          if (pop) begin
            head_d  = skid_q;
            state_d = StOne;
          end
        end
        default: begin
          state_d = StEmpty;
          head_d  = RESET_VAL;
          skid_d  = RESET_VAL;
        end
      endcase
    end
  end

  // State and entry registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StEmpty;
      head_q  <= RESET_VAL;
      skid_q  <= RESET_VAL;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
    end
  end

endmodule
